// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Holds the loader FSM state type, the number of byte lanes per memory
// word and the number of length-header bytes in a frame.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } loader_state_t;

  localparam int LANES     = 4;
  localparam int LEN_BYTES = 2;

endpackage

// File: rtl/byte_lane_packer.sv
// Byte lane packer: collects stream bytes into a 4-lane little-endian
// word buffer and issues one registered word write per completed word.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_clear         discard any partially filled word
//   i_byte_valid    a payload byte is accepted this cycle
//   i_byte          payload byte
//   i_lane          lane the byte belongs to (byte index [1:0])
//   i_last          this byte is the final payload byte
//   i_word_addr     word-aligned byte address of the word being filled
//   o_we            one-cycle write strobe, the cycle after completion
//   o_be            lanes filled in the written word
//   o_addr          write address
//   o_wdata         write data, unfilled lanes are 0
module byte_lane_packer
  import loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_byte_valid,
  input  logic [7:0]               i_byte,
  input  logic [1:0]               i_lane,
  input  logic                     i_last,
  input  logic [ADDRESS_WIDTH-1:0] i_word_addr,
  output logic                     o_we,
  output logic [LANES-1:0]         o_be,
  output logic [ADDRESS_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0]    o_wdata
);

  logic [DATA_WIDTH-1:0] r_buf;
  logic [LANES-1:0]      r_be;

  logic [DATA_WIDTH-1:0] w_lane_data;
  logic [LANES-1:0]      w_lane_be;
  logic [DATA_WIDTH-1:0] w_buf_next;
  logic [LANES-1:0]      w_be_next;
  logic                  w_complete;

  assign w_lane_data = DATA_WIDTH'(i_byte) << {i_lane, 3'b000};
  assign w_lane_be   = LANES'(1) << i_lane;
  assign w_buf_next  = r_buf | w_lane_data;
  assign w_be_next   = r_be | w_lane_be;
  assign w_complete  = i_byte_valid & ((i_lane == 2'd3) | i_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_be    <= '0;
      o_we    <= 1'b0;
      o_be    <= '0;
      o_addr  <= '0;
      o_wdata <= '0;
    end else begin
      o_we <= w_complete;
      if (w_complete) begin
        o_be    <= w_be_next;
        o_addr  <= i_word_addr;
        o_wdata <= w_buf_next;
      end else begin
        o_be    <= '0;
        o_addr  <= '0;
        o_wdata <= '0;
      end
      // The buffer empties on the completing edge so the next byte can
      // land in lane 0 without a stall.
      if (i_clear || w_complete) begin
        r_buf <= '0;
        r_be  <= '0;
      end else if (i_byte_valid) begin
        r_buf <= w_buf_next;
        r_be  <= w_be_next;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a frame LEN[7:0], LEN[15:8], payload, XOR
// checksum over a valid/ready byte stream and writes the payload into
// instruction memory as little-endian 32-bit words starting at BASE_ADDR.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begins a load when idle
//   in_valid/in_data    byte stream from the host
//   in_ready            loader accepts the byte this cycle
//   mem_we/be/addr/wdata  instruction-memory word write port
//   cpu_hold            holds the CPU in reset while loading
//   busy                loader not idle
//   done                one-cycle end-of-load pulse
//   load_err            sticky result of the last load
//   dbg_state           current FSM state
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1; in_valid may drop at any time and the loader simply waits.
module program_loader
  import loader_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                     MAX_BYTES     = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [3:0]               mem_be,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     load_err,
  output loader_state_t            dbg_state
);

  loader_state_t r_state;
  logic [15:0]   r_len;
  logic [15:0]   r_cnt;
  logic [7:0]    r_csum;
  logic          r_err;

  logic                     w_in_ready;
  logic                     w_fire;
  logic [15:0]              w_len_full;
  logic                     w_last;
  logic                     w_data_byte;
  logic                     w_clear;
  logic [ADDRESS_WIDTH-1:0] w_word_addr;

  assign w_in_ready  = (r_state == LEN0) | (r_state == LEN1) |
                       (r_state == DATA) | (r_state == CSUM);
  assign w_fire      = in_valid & w_in_ready;
  assign w_len_full  = {in_data, r_len[7:0]};
  assign w_last      = (r_cnt == (r_len - 16'd1));
  assign w_data_byte = w_fire & (r_state == DATA);
  assign w_clear     = (r_state == IDLE) & start;
  assign w_word_addr = BASE_ADDR + ADDRESS_WIDTH'({r_cnt[15:2], 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LEN0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_csum  <= '0;
            r_err   <= 1'b0;
          end
        end
        LEN0: begin
          if (w_fire) begin
            r_len[7:0] <= in_data;
            r_state    <= LEN1;
          end
        end
        LEN1: begin
          if (w_fire) begin
            r_len <= w_len_full;
            r_cnt <= '0;
            // Oversized images are rejected before any write happens.
            if ({1'b0, w_len_full} > 17'(MAX_BYTES)) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else if (w_len_full == 16'd0) begin
              r_state <= CSUM;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_fire) begin
            r_csum <= r_csum ^ in_data;
            r_cnt  <= r_cnt + 16'd1;
            if (w_last) r_state <= CSUM;
          end
        end
        CSUM: begin
          if (w_fire) begin
            r_err   <= (in_data != r_csum);
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  byte_lane_packer #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_byte_valid(w_data_byte),
    .i_byte      (in_data),
    .i_lane      (r_cnt[1:0]),
    .i_last      (w_last),
    .i_word_addr (w_word_addr),
    .o_we        (mem_we),
    .o_be        (mem_be),
    .o_addr      (mem_addr),
    .o_wdata     (mem_wdata)
  );

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != IDLE);
  assign cpu_hold  = busy;
  assign done      = (r_state == DONE);
  assign load_err  = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import loader_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] BASE = '0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          load_err;
  loader_state_t dbg_state;

  program_loader #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .BASE_ADDR    (BASE),
    .MAX_BYTES    (256)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .load_err (load_err),
    .dbg_state(dbg_state)
  );

  // scoreboard: {addr, be, wdata}
  logic [AW+4+DW-1:0] exp_q[$];
  logic [7:0]         pay_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {mem_addr, mem_be, mem_wdata}, 72'h0);
      end else begin
        check("mem_write", {mem_addr, mem_be, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks; all leave time at #1 after a rising edge
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  g;
    bit  ok;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    in_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      check("handshake_timeout", 72'd0, 72'd1);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_payload();
    logic [7:0] x = 8'h00;
    foreach (pay_q[i]) x ^= pay_q[i];
    return x;
  endfunction

  // sends the length header and the first n payload bytes, pushing the
  // word writes the memory should see
  task automatic send_header_payload(input int n, input int gap);
    int          len;
    logic [31:0] wbuf;
    logic [3:0]  wbe;
    len = pay_q.size();
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    wbuf = '0;
    wbe  = '0;
    for (int i = 0; i < n; i++) begin
      wbuf = wbuf | (32'(pay_q[i]) << (8 * (i % 4)));
      wbe  = wbe | (4'b0001 << (i % 4));
      if ((i % 4 == 3) || (i == len - 1)) begin
        exp_q.push_back({BASE + AW'(4 * (i / 4)), wbe, wbuf});
        wbuf = '0;
        wbe  = '0;
      end
      send_byte(pay_q[i], gap);
    end
  endtask

  task automatic run_load(input bit bad_csum, input int gap, input logic exp_err);
    logic [7:0] cs;
    pulse_start();
    @(negedge clk);
    check("err_clear_on_start", 72'(load_err), 72'd0);
    check("hold_in_load", 72'({cpu_hold, busy}), 72'b11);
    @(posedge clk); #1;
    send_header_payload(pay_q.size(), gap);
    cs = xor_payload() ^ (bad_csum ? 8'hFF : 8'h00);
    send_byte(cs, gap);
    @(negedge clk);
    check("done", 72'(done), 72'd1);
    check("load_err", 72'(load_err), 72'(exp_err));
    @(negedge clk);
    check("done_one_cycle", 72'(done), 72'd0);
    check("hold_released", 72'({cpu_hold, busy}), 72'b00);
    check("writes_drained", 72'(exp_q.size()), 72'd0);
    @(posedge clk); #1;
  endtask

  task automatic set_prog1();
    pay_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'hF0, 8'h0F};
  endtask

  initial begin
    // reset state
    #12;
    check("reset_outputs", 72'({in_ready, mem_we, mem_be, mem_addr, mem_wdata, cpu_hold, busy, done, load_err}), 72'd0);
    check("reset_state", 72'(dbg_state), 72'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic two-word program
    set_prog1();
    run_load(1'b0, 0, 1'b0);

    // 2: partial final word
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_load(1'b0, 0, 1'b0);

    // 3: oversize length
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    check("oversize_done", 72'(done), 72'd1);
    check("oversize_err", 72'(load_err), 72'd1);
    check("oversize_not_ready", 72'(in_ready), 72'd0);
    @(negedge clk);
    check("oversize_idle", 72'({in_ready, busy, done}), 72'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // 4: wrong checksum, then a clean load clears the error
    pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    run_load(1'b1, 0, 1'b1);
    set_prog1();
    run_load(1'b0, 0, 1'b0);

    // 5: random idle gaps between bytes
    set_prog1();
    run_load(1'b0, 5, 1'b0);

    // zero-length image: only a checksum of 0
    pay_q = {};
    run_load(1'b0, 0, 1'b0);

    // 6: reset after 6 of 8 payload bytes
    set_prog1();
    pulse_start();
    send_header_payload(6, 0);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 72'({in_ready, mem_we, mem_be, mem_addr, mem_wdata, cpu_hold, busy, done, load_err}), 72'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_no_pending", 72'(exp_q.size()), 72'd0);
    check("abort_idle", 72'(dbg_state), 72'(IDLE));
    set_prog1();
    run_load(1'b0, 2, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    check("final_queue_empty", 72'(exp_q.size()), 72'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
